// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch port and the data port.
// Optional fetch anti-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be 1..4");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_MAX must be 1..15");
  end

  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;  // 1 = data port owns the transaction
  logic [1:0]  wait_q, wait_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        fetch_win;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0]  starve_q, starve_d;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    be_d       = be_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    fetch_win  = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    starve_d   = starve_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef ARB_STARVE_GUARD_EN
        fetch_win = if_req && (!d_req || (starve_q == STARVE_LIM));
`else
        fetch_win = if_req && !d_req;
`endif
        // No grant while in reset: the accepted request would be lost.
        if (!rst) begin
          if_gnt = fetch_win;
          d_gnt  = d_req && !fetch_win;
        end

        if (if_gnt) begin
          owner_d = 1'b0;
          addr_d  = if_addr;
          we_d    = 1'b0;
          be_d    = 4'h0;
          wdata_d = 32'h0;
          state_d = S_ISSUE;
        end else if (d_gnt) begin
          owner_d = 1'b1;
          addr_d  = d_addr;
          we_d    = d_we;
          be_d    = d_be;
          wdata_d = d_wdata;
          state_d = S_ISSUE;
        end

`ifdef ARB_STARVE_GUARD_EN
        if (!if_req || if_gnt) begin
          starve_d = 4'd0;
        end else if (d_gnt && (starve_q != STARVE_LIM)) begin
          starve_d = starve_q + 4'd1;
        end
`endif
      end

      S_ISSUE: begin
        wait_d  = 2'd0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // mem_rdata is valid on the last wait cycle only.
        if (wait_q == LAT_LAST) begin
          state_d = S_RESP;
          if (owner_q) begin
            d_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      wait_q     <= 2'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      we_q       <= 1'b0;
      be_q       <= 4'h0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
`ifdef ARB_STARVE_GUARD_EN
      starve_q   <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      be_q       <= be_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_q   <= starve_d;
`endif
    end
  end

  assign mem_en    = (state_q == S_ISSUE);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign if_rvalid = (state_q == S_RESP) && !owner_q;
  assign d_rvalid  = (state_q == S_RESP) && owner_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-accurate memory model and
// a response scoreboard; exercises fetch, contention, write, priority and reset.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int NGRANT = GUARD ? 8 : 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return {22'h0, if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, mem_be,
            mem_addr, mem_wdata, if_rdata, d_rdata};
  endfunction

  // Memory model: preset contents, byte-enabled writes, read data valid LAT cycles after mem_en.
  logic [31:0] mem [int unsigned];
  logic [31:0] rpipe [0:4];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    case (a)
      32'h100: return 32'h0050_0093;
      32'h008: return 32'h3333_4444;
      32'h400: return 32'h1111_2222;
      32'h200: return 32'h1234_5678;
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [31:0] w;
    for (int i = 4; i > 0; i--) rpipe[i] = rpipe[i-1];
    rpipe[0] = 32'hDEAD_0000;
    if (mem_en && !mem_we) rpipe[0] = rd(mem_addr);
    if (mem_en && mem_we) begin
      w = rd(mem_addr);
      for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
      mem[mem_addr] = w;
    end
    mem_rdata = rpipe[LAT];
  end

  typedef struct {
    bit          is_d;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic exp_push(input bit is_d, input bit c, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.chk_data = c;
    e.data = data;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (if_rvalid || d_rvalid)) begin
      chk("rvalid_gnt_exclusive", {if_gnt, d_gnt}, 0);
      chk("rvalid_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rvalid_port", {if_rvalid, d_rvalid}, {~e.is_d, e.is_d});
        if (e.chk_data) chk("rdata", e.is_d ? d_rdata : if_rdata, e.data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Called in the grant cycle after sampling; runs the transaction to its response.
  task automatic after_grant(input bit is_d, input logic [31:0] addr, input bit we,
                             input logic [3:0] be, input logic [31:0] wdata,
                             input bit drop_if, input bit drop_d, input string tag);
    cyc();
    if (drop_if) if_req = 1'b0;
    if (drop_d) d_req = 1'b0;
    samp();
    chk({tag, "_issue"}, {mem_en, mem_we, mem_be, mem_addr}, {1'b1, we, be, addr});
    if (we) chk({tag, "_wdata"}, mem_wdata, wdata);
    for (int i = 2; i <= 1 + LAT; i++) begin
      cyc();
      samp();
      chk({tag, "_wait"}, {mem_en, if_rvalid, d_rvalid, if_gnt, d_gnt}, 0);
    end
    cyc();
    samp();
    chk({tag, "_resp"}, {if_rvalid, d_rvalid, if_gnt, d_gnt}, {~is_d, is_d, 2'b00});
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit f;
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    cyc();
    cyc();
    samp();
    chk("reset_outputs", all_outs(), 0);
    cyc();
    rst = 1'b0;

    // Fetch only
    if_req = 1'b1; if_addr = 32'h100;
    exp_push(1'b0, 1'b1, 32'h0050_0093);
    samp();
    chk("fetch_gnt", {if_gnt, d_gnt}, 2'b10);
    after_grant(1'b0, 32'h100, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, "fetch");

    // Contention: data first, fetch next IDLE
    if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    exp_push(1'b1, 1'b1, 32'h1111_2222);
    samp();
    chk("contend_gnt", {if_gnt, d_gnt}, 2'b01);
    after_grant(1'b1, 32'h400, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, "contend_d");
    exp_push(1'b0, 1'b1, 32'h3333_4444);
    samp();
    chk("contend_fetch_next", {if_gnt, d_gnt}, 2'b10);
    after_grant(1'b0, 32'h8, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, "contend_f");

    // Write with partial byte enables, then read it back
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    exp_push(1'b1, 1'b0, 32'h0);
    samp();
    chk("write_gnt", {if_gnt, d_gnt}, 2'b01);
    after_grant(1'b1, 32'h200, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1'b0, 1'b1, "write");
    d_we = 1'b0; d_be = 4'h0; d_req = 1'b1;
    exp_push(1'b1, 1'b1, 32'h1234_BEEF);
    samp();
    chk("readback_gnt", {if_gnt, d_gnt}, 2'b01);
    after_grant(1'b1, 32'h200, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, "readback");

    // Both requests held: strict data priority, or forced fetch every fourth grant
    if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_addr = 32'h400;
    for (int g = 0; g < NGRANT; g++) begin
      f = GUARD && ((g % 4) == 3);
      if (f) exp_push(1'b0, 1'b1, 32'h3333_4444);
      else   exp_push(1'b1, 1'b1, 32'h1111_2222);
      samp();
      chk($sformatf("prio_gnt%0d", g), {if_gnt, d_gnt}, f ? 2'b10 : 2'b01);
      after_grant(!f, f ? 32'h8 : 32'h400, 1'b0, 4'h0, 32'h0, 1'b0, g == NGRANT - 1,
                  $sformatf("prio%0d", g));
    end
    exp_push(1'b0, 1'b1, 32'h3333_4444);
    samp();
    chk("fetch_after_d_drop", {if_gnt, d_gnt}, 2'b10);
    after_grant(1'b0, 32'h8, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, "fetch_late");

    // Reset during WAIT of a fetch drops it
    if_req = 1'b1; if_addr = 32'h100;
    samp();
    chk("rst_fetch_gnt", {if_gnt, d_gnt}, 2'b10);
    cyc();
    if_req = 1'b0;
    samp();
    chk("rst_fetch_issue", mem_en, 1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    samp();
    chk("post_rst_outputs", all_outs(), 0);
    cyc();
    for (int i = 0; i < LAT + 2; i++) begin
      samp();
      chk("no_stale_rvalid", {if_rvalid, d_rvalid}, 0);
      cyc();
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    exp_push(1'b1, 1'b1, 32'h1111_2222);
    samp();
    chk("post_rst_d_gnt", {if_gnt, d_gnt}, 2'b01);
    after_grant(1'b1, 32'h400, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, "post_rst_d");

    cyc();
    cyc();
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-port synchronous unified memory between the IF-stage instruction fetch port and the EX-stage data port of the 3-stage core. It accepts one transaction at a time, issues it to memory, waits a fixed memory latency, and returns read data or a write acknowledge to the owning requester. The IF and EX stages stall on their respective port while waiting for a grant or a response.

## Interface
- MEM_LAT, 1: memory read latency in cycles, legal range 1..4. mem_rdata is valid exactly MEM_LAT cycles after the mem_en cycle.
- STARVE_MAX, 3: contention cycles fetch loses before it is forced to win, legal range 1..15.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held, with if_addr stable, until if_gnt.
- if_addr  in  32  fetch address.
- if_gnt  out  1  fetch request accepted (combinational, IDLE only).
- if_rvalid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  32  fetched word, registered.
- d_req  in  1  data request; held, with its payload stable, until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_be  in  4  write byte enables.
- d_gnt  out  1  data request accepted (combinational, IDLE only).
- d_rvalid  out  1  one-cycle pulse: read data valid, or write complete.
- d_rdata  out  32  read data, registered; don't-care on writes.
- mem_en  out  1  one-cycle memory access strobe.
- mem_we  out  1  write strobe, qualified by mem_en.
- mem_addr  out  32  registered access address.
- mem_wdata  out  32  registered write data.
- mem_be  out  4  registered byte enables; 4'h0 on fetch.
- mem_rdata  in  32  memory read data.

## Operation
- FSM states and transitions:
  - IDLE: accepts a request and moves to ISSUE; stays in IDLE if there is no request.
  - ISSUE: one cycle, mem_en=1; moves to WAIT.
  - WAIT: exactly MEM_LAT cycles; moves to RESP.
  - RESP: one cycle, rvalid pulse to the owner; moves to IDLE.
- Grants are asserted only in IDLE. Requests arriving in any other state wait; the requester keeps its request held.
- On accept:
  - Latch the owner (IF or D), address, we, wdata and be into mem_* registers.
  - Fetch accesses always have mem_we=0 and mem_be=0.
- Priority:
  - Default: data beats fetch.
  - When starve_cnt == STARVE_MAX, fetch beats data.
- starve_cnt (4 bits):
  - Increments in an IDLE cycle with if_req&&d_req when data is granted.
  - Clears when fetch is granted, or in any IDLE cycle with if_req=0.
  - Saturates at STARVE_MAX.
- Capture and response:
  - mem_rdata is captured into the owner's rdata register on the last WAIT cycle.
  - RESP pulses only the owner's rvalid. The other port's rdata register holds its value.
- Writes follow the same path and latency as reads. d_rvalid is the write acknowledge.
- rst during any state:
  - Next state is IDLE.
  - Outstanding transaction is dropped; no rvalid is produced for it.
  - starve_cnt=0; all outputs are 0.
  - A write whose mem_en has already been issued is not retracted.

## Timing
- Reset values: every output 0, state IDLE, starve_cnt 0, rdata registers 0.
- Request accepted in cycle T (gnt high in T):
  - mem_en in T+1.
  - WAIT in T+2..T+1+MEM_LAT.
  - rvalid in T+2+MEM_LAT.
  - Next grant possible at the earliest in T+3+MEM_LAT.
- Throughput: one transaction per MEM_LAT+3 cycles.
- Simultaneous if_req and d_req in IDLE: exactly one grant per the priority rule. The loser receives no grant and must hold its request.
- A requester may drop its request the cycle after its grant. A request that deasserts before being granted is never issued.
- gnt is never asserted in the same cycle as rvalid.

## Configuration
- Macro ARB_STARVE_GUARD_EN.
  - Defined: starve_cnt and the forced fetch win are present as described.
  - Undefined: strict data priority. starve_cnt is not implemented, STARVE_MAX is ignored, and fetch is granted only in IDLE cycles with d_req=0.

## Test plan
- Fetch only (MEM_LAT=2):
  - Stimulus: if_req with if_addr=0x100 at cycle 0; memory returns 0x00500093.
  - Required response: if_gnt in cycle 0; mem_en=1, mem_addr=0x100, mem_we=0 in cycle 1; if_rvalid=1 with if_rdata=0x00500093 in cycle 4; d_rvalid stays 0.
- Contention (MEM_LAT=1):
  - Stimulus: if_req (addr 0x8) and d_req read (addr 0x400) in the same IDLE cycle.
  - Required response: d_gnt=1 and if_gnt=0; the data read completes with d_rvalid 3 cycles after grant; fetch is then granted in the next IDLE cycle.
- Starvation (guard on, STARVE_MAX=3):
  - Stimulus: if_req and d_req held continuously.
  - Required response: data wins the first three contended grants; the fourth grant goes to fetch; starve_cnt returns to 0.
- Write (MEM_LAT=1):
  - Stimulus: d_req write, d_addr=0x200, d_wdata=0xDEADBEEF, d_be=4'b0011.
  - Required response: exactly one cycle with mem_en=1, mem_we=1, mem_be=0011 and those address and data values; then a single d_rvalid pulse.
- Reset mid-WAIT:
  - Stimulus: rst asserted one cycle during WAIT of a fetch.
  - Required response: no if_rvalid; all outputs 0 in the cycle after rst; a subsequent d_req read completes normally.
- Guard compiled out:
  - Stimulus: d_req held for 20 cycles with if_req also held.
  - Required response: if_gnt never asserts while d_req is high; if_gnt asserts in the first IDLE cycle after d_req drops.
